nvdla_csb_arb: RTL and testbench

NVDLA_CSB_ARB -- requirements
Module: nvdla_csb_arb

---
 rtl/nvdla_csb_arb.sv | 177 +++++++++++++++++
 tb/tb_nvdla_csb_arb.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/nvdla_csb_arb.sv
// rtl/nvdla_csb_arb.sv - round-robin arbiter funnelling CSB requesters onto one engine
// One transaction in flight: grant, issue, wait for engine flag or interrupt, respond.
module nvdla_csb_arb #(
  parameter int NB_REQ    = 2,
  parameter int TIMEOUT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic [NB_REQ-1:0]      req_valid_i,
  output logic [NB_REQ-1:0]      req_ready_o,
  input  logic [NB_REQ*16-1:0]   req_addr_i,
  input  logic [NB_REQ*32-1:0]   req_wdat_i,
  input  logic [NB_REQ-1:0]      req_write_i,
  input  logic [NB_REQ-1:0]      req_wait_intr_i,
  input  logic [TIMEOUT_W-1:0]   timeout_i,
  output logic [NB_REQ-1:0]      resp_valid_o,
  output logic [31:0]            resp_rdata_o,
  output logic                   resp_err_o,
  output logic                   eng_start_o,
  output logic [15:0]            eng_addr_o,
  output logic [31:0]            eng_wdat_o,
  output logic                   eng_write_o,
  output logic                   eng_wait_intr_o,
  input  logic [31:0]            eng_rdata_i,
  input  logic                   eng_rvalid_i,
  input  logic                   eng_wr_complete_i,
  input  logic                   eng_intr_i,
  output logic                   busy_o
);

  localparam int PTR_W = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ISSUE     = 3'd1;
  localparam logic [2:0] ST_WAIT_RD   = 3'd2;
  localparam logic [2:0] ST_WAIT_WR   = 3'd3;
  localparam logic [2:0] ST_WAIT_INTR = 3'd4;
  localparam logic [2:0] ST_RESP      = 3'd5;

  logic [2:0]           state_q;
  logic [PTR_W-1:0]     ptr_q;
  logic [PTR_W-1:0]     gnt_q;
  logic [TIMEOUT_W-1:0] cnt_q;
  logic [15:0]          addr_q;
  logic [31:0]          wdat_q;
  logic                 write_q;
  logic                 wait_q;
  logic [31:0]          rdata_q;
  logic                 err_q;

  logic                 found;
  logic [PTR_W-1:0]     win;
  logic [PTR_W:0]       pos;
  logic [15:0]          sel_addr;
  logic [31:0]          sel_wdat;
  logic                 sel_write;
  logic                 sel_wait;
  logic                 timeout_hit;

  // First valid requester at or above ptr, wrapping back to 0.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    pos   = '0;
    for (int k = 0; k < NB_REQ; k++) begin
      pos = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (pos >= (PTR_W+1)'(NB_REQ)) begin
        pos = pos - (PTR_W+1)'(NB_REQ);
      end
      if (!found && req_valid_i[pos[PTR_W-1:0]]) begin
        found = 1'b1;
        win   = pos[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdat  = '0;
    sel_write = 1'b0;
    sel_wait  = 1'b0;
    for (int i = 0; i < NB_REQ; i++) begin
      if (PTR_W'(i) == win) begin
        sel_addr  = req_addr_i[16*i +: 16];
        sel_wdat  = req_wdat_i[32*i +: 32];
        sel_write = req_write_i[i];
        sel_wait  = req_wait_intr_i[i];
      end
    end
  end

  assign timeout_hit = (timeout_i != '0) && (cnt_q == timeout_i - TIMEOUT_W'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdat_q  <= '0;
      write_q <= 1'b0;
      wait_q  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (found) begin
            gnt_q   <= win;
            addr_q  <= sel_addr;
            wdat_q  <= sel_wdat;
            write_q <= sel_write;
            wait_q  <= sel_wait;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt_q <= '0;
          if (wait_q) begin
            state_q <= ST_WAIT_INTR;
          end else if (write_q) begin
            state_q <= ST_WAIT_WR;
          end else begin
            state_q <= ST_WAIT_RD;
          end
        end
        ST_WAIT_RD: begin
          if (eng_rvalid_i) begin
            rdata_q <= eng_rdata_i;
            err_q   <= 1'b0;
            state_q <= ST_RESP;
          end
        end
        ST_WAIT_WR: begin
          if (eng_wr_complete_i) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
            state_q <= ST_RESP;
          end
        end
        ST_WAIT_INTR: begin
          // Interrupt beats a timeout landing in the same cycle.
          if (eng_intr_i) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
            state_q <= ST_RESP;
          end else if (timeout_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state_q <= ST_RESP;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + TIMEOUT_W'(1);
          end
        end
        ST_RESP: begin
          ptr_q   <= (gnt_q == PTR_W'(NB_REQ-1)) ? '0 : gnt_q + PTR_W'(1);
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o     = (state_q == ST_IDLE && found) ? (NB_REQ'(1) << win) : '0;
  assign resp_valid_o    = (state_q == ST_RESP) ? (NB_REQ'(1) << gnt_q) : '0;
  assign resp_rdata_o    = rdata_q;
  assign resp_err_o      = err_q;
  assign eng_start_o     = (state_q == ST_ISSUE);
  assign eng_addr_o      = (state_q == ST_IDLE) ? '0 : addr_q;
  assign eng_wdat_o      = (state_q == ST_IDLE) ? '0 : wdat_q;
  assign eng_write_o     = (state_q == ST_IDLE) ? 1'b0 : write_q;
  assign eng_wait_intr_o = (state_q == ST_IDLE) ? 1'b0 : wait_q;
  assign busy_o          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_nvdla_csb_arb.sv
// tb/tb_nvdla_csb_arb.sv - directed self-checking bench for nvdla_csb_arb
// Inputs change 2ns after the rising edge; outputs are sampled 1ns later.
module tb_nvdla_csb_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_addr;
  logic [63:0] req_wdat;
  logic [1:0]  req_write;
  logic [1:0]  req_wait_intr;
  logic [15:0] timeout;
  logic [1:0]  resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        eng_start;
  logic [15:0] eng_addr;
  logic [31:0] eng_wdat;
  logic        eng_write;
  logic        eng_wait_intr;
  logic [31:0] eng_rdata;
  logic        eng_rvalid;
  logic        eng_wr_complete;
  logic        eng_intr;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  nvdla_csb_arb #(.NB_REQ(2), .TIMEOUT_W(16)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .clear_i           (clear),
    .req_valid_i       (req_valid),
    .req_ready_o       (req_ready),
    .req_addr_i        (req_addr),
    .req_wdat_i        (req_wdat),
    .req_write_i       (req_write),
    .req_wait_intr_i   (req_wait_intr),
    .timeout_i         (timeout),
    .resp_valid_o      (resp_valid),
    .resp_rdata_o      (resp_rdata),
    .resp_err_o        (resp_err),
    .eng_start_o       (eng_start),
    .eng_addr_o        (eng_addr),
    .eng_wdat_o        (eng_wdat),
    .eng_write_o       (eng_write),
    .eng_wait_intr_o   (eng_wait_intr),
    .eng_rdata_i       (eng_rdata),
    .eng_rvalid_i      (eng_rvalid),
    .eng_wr_complete_i (eng_wr_complete),
    .eng_intr_i        (eng_intr),
    .busy_o            (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  exp_mask;
    logic [31:0] exp_wdat;

    rst = 1'b1; clear = 1'b0; req_valid = '0; req_addr = '0; req_wdat = '0;
    req_write = '0; req_wait_intr = '0; timeout = '0; eng_rdata = '0;
    eng_rvalid = 1'b0; eng_wr_complete = 1'b0; eng_intr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_busy",  32'(busy), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_resp",  32'(resp_valid), 32'h0);
    chk("rst_start", 32'(eng_start), 32'h0);
    chk("rst_addr",  32'(eng_addr), 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_err",   32'(resp_err), 32'h0);

    // Single read from requester 0
    req_valid = 2'b01; req_addr = {16'h0000, 16'h5000};
    #1 chk("rd_grant", 32'(req_ready), 32'h1);
    tick(); req_valid = '0;
    #1 chk("rd_start", 32'(eng_start), 32'h1);
    chk("rd_addr1", 32'(eng_addr), 32'h5000);
    chk("rd_write", 32'(eng_write), 32'h0);
    chk("rd_busy",  32'(busy), 32'h1);
    chk("rd_ready0", 32'(req_ready), 32'h0);
    tick();
    #1 chk("rd_start_off", 32'(eng_start), 32'h0);
    chk("rd_addr2", 32'(eng_addr), 32'h5000);
    tick(); eng_rvalid = 1'b1; eng_rdata = 32'hDEADBEEF;
    #1 chk("rd_noresp", 32'(resp_valid), 32'h0);
    tick(); eng_rvalid = 1'b0; eng_rdata = '0;
    #1 chk("rd_resp", 32'(resp_valid), 32'h1);
    chk("rd_rdata", resp_rdata, 32'hDEADBEEF);
    chk("rd_err",   32'(resp_err), 32'h0);
    tick();
    #1 chk("rd_resp_off", 32'(resp_valid), 32'h0);
    chk("rd_rdata_hold", resp_rdata, 32'hDEADBEEF);
    chk("rd_idle", 32'(busy), 32'h0);
    chk("rd_addr_idle", 32'(eng_addr), 32'h0);

    // Stray write-complete while waiting on a read (requester 1)
    req_valid = 2'b10; req_addr = {16'h1234, 16'h0000};
    #1 chk("stray_grant", 32'(req_ready), 32'h2);
    tick(); req_valid = '0;
    tick(); eng_wr_complete = 1'b1;
    tick(); eng_wr_complete = 1'b0;
    #1 chk("stray_noresp", 32'(resp_valid), 32'h0);
    chk("stray_busy", 32'(busy), 32'h1);
    tick(); eng_rvalid = 1'b1; eng_rdata = 32'h0BADF00D;
    tick(); eng_rvalid = 1'b0; eng_rdata = '0;
    #1 chk("stray_resp", 32'(resp_valid), 32'h2);
    chk("stray_rdata", resp_rdata, 32'h0BADF00D);
    tick();

    // Contention: both requesters writing continuously
    req_valid = 2'b11; req_write = 2'b11; req_wdat = {32'hB1B1B1B1, 32'hA0A0A0A0};
    for (int t = 0; t < 4; t++) begin
      exp_mask = (t % 2 == 0) ? 2'b01 : 2'b10;
      exp_wdat = (t % 2 == 0) ? 32'hA0A0A0A0 : 32'hB1B1B1B1;
      #1 chk("cont_grant", 32'(req_ready), 32'(exp_mask));
      tick();
      #1 chk("cont_ready_issue", 32'(req_ready), 32'h0);
      chk("cont_start", 32'(eng_start), 32'h1);
      chk("cont_write", 32'(eng_write), 32'h1);
      chk("cont_wdat", eng_wdat, exp_wdat);
      tick(); eng_wr_complete = 1'b1;
      #1 chk("cont_ready_wait", 32'(req_ready), 32'h0);
      tick(); eng_wr_complete = 1'b0;
      #1 chk("cont_resp", 32'(resp_valid), 32'(exp_mask));
      chk("cont_rdata", resp_rdata, 32'h0);
      chk("cont_ready_resp", 32'(req_ready), 32'h0);
      tick();
    end
    req_valid = '0; req_write = '0;

    // Interrupt-wait timeout, requester 0 (wait_intr overrides write)
    timeout = 16'd5; req_valid = 2'b01; req_wait_intr = 2'b01; req_write = 2'b01;
    #1 chk("to_grant", 32'(req_ready), 32'h1);
    tick(); req_valid = '0;
    #1 chk("to_wait_mode", 32'(eng_wait_intr), 32'h1);
    for (int c = 2; c <= 6; c++) begin
      tick();
      #1 chk("to_noresp", 32'(resp_valid), 32'h0);
    end
    tick();
    #1 chk("to_resp", 32'(resp_valid), 32'h1);
    chk("to_err", 32'(resp_err), 32'h1);
    tick();
    #1 chk("to_err_hold", 32'(resp_err), 32'h1);
    req_wait_intr = '0; req_write = '0;

    // Clear during WAIT_RD, pointer at 1 beforehand
    req_valid = 2'b01; req_addr = {16'h0000, 16'hABCD};
    #1 chk("clr_grant", 32'(req_ready), 32'h1);
    tick(); req_valid = '0;
    tick(); clear = 1'b1;
    tick(); clear = 1'b0; eng_rvalid = 1'b1; eng_rdata = 32'h12345678;
    #1 chk("clr_busy", 32'(busy), 32'h0);
    chk("clr_addr", 32'(eng_addr), 32'h0);
    chk("clr_resp", 32'(resp_valid), 32'h0);
    chk("clr_rdata", resp_rdata, 32'h0);
    chk("clr_err", 32'(resp_err), 32'h0);
    tick(); eng_rvalid = 1'b0; eng_rdata = '0;
    #1 chk("clr_late_resp", 32'(resp_valid), 32'h0);
    chk("clr_late_busy", 32'(busy), 32'h0);
    req_valid = 2'b11;
    #1 chk("clr_ptr0", 32'(req_ready), 32'h1);
    tick(); req_valid = '0;
    tick(); eng_rvalid = 1'b1; eng_rdata = 32'h55AA55AA;
    tick(); eng_rvalid = 1'b0; eng_rdata = '0;
    #1 chk("clr_after_resp", 32'(resp_valid), 32'h1);
    chk("clr_after_rdata", resp_rdata, 32'h55AA55AA);
    tick();

    // Interrupt arriving in the timeout cycle, requester 1
    req_valid = 2'b10; req_wait_intr = 2'b10;
    #1 chk("race_grant", 32'(req_ready), 32'h2);
    tick(); req_valid = '0;
    tick(); tick(); tick(); tick();
    tick(); eng_intr = 1'b1;
    #1 chk("race_noresp", 32'(resp_valid), 32'h0);
    tick(); eng_intr = 1'b0;
    #1 chk("race_resp", 32'(resp_valid), 32'h2);
    chk("race_err", 32'(resp_err), 32'h0);
    tick();
    #1 chk("race_idle", 32'(busy), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
